alu_iter: RTL and testbench

Parametrised successor to the single-cycle datapath ALU. It is a registered, handshaked ALU of width `WIDTH` with an extended opcode set: arithmetic, logic, compare and shift ops complete in one cycle, while unsigned multiply, divide and remainder run iteratively over `WIDTH` cycles. It sits between the decode/register-read stage and writeback of the multi-cycle core and reports NZCV flags plus a divide-by-zero indication alongside each result.

---
 rtl/alu_iter.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_iter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter
// Purpose  : Registered, handshaked ALU. Single-cycle arithmetic, logic,
//            compare and shift ops; iterative MUL, DIVU and REMU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             div_zero
);

  localparam int c_sh_w  = $clog2(WIDTH);
  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_xor  = 4'd4;
  localparam logic [3:0] c_op_slt  = 4'd5;
  localparam logic [3:0] c_op_sltu = 4'd6;
  localparam logic [3:0] c_op_sll  = 4'd7;
  localparam logic [3:0] c_op_srl  = 4'd8;
  localparam logic [3:0] c_op_sra  = 4'd9;
  localparam logic [3:0] c_op_mul  = 4'd10;
  localparam logic [3:0] c_op_divu = 4'd11;
  localparam logic [3:0] c_op_remu = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_op;
  logic [WIDTH-1:0]     r_x;    // MUL: shifted multiplicand; DIV: dividend bits / quotient
  logic [WIDTH-1:0]     r_y;    // MUL: multiplier shifting right; DIV: divisor
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH:0]       r_rem;  // partial remainder with next dividend bit already shifted in
  logic [WIDTH-1:0]     r_result;
  logic                 r_n, r_z, r_c, r_v, r_dz;

  logic                 w_accept;
  logic                 w_sub, w_cout, w_ovf, w_iter;
  logic [WIDTH-1:0]     w_bop, w_sum, w_res;
  logic                 w_c, w_v, w_dz;
  logic [c_sh_w-1:0]    w_shamt;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff, w_acc_nxt, w_fin;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flag_n    = r_n;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_v    = r_v;
  assign div_zero  = r_dz;

  // Single-cycle result path, evaluated on the offered operands
  always_comb begin
    w_sub   = (op != c_op_add);
    w_bop   = w_sub ? ~b : b;
    {w_cout, w_sum} = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};
    w_ovf   = (a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_shamt = b[c_sh_w-1:0];
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_dz    = 1'b0;
    w_iter  = 1'b0;
    case (op)
      c_op_add, c_op_sub: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_v   = w_ovf;
      end
      c_op_and:  w_res = a & b;
      c_op_or:   w_res = a | b;
      c_op_xor:  w_res = a ^ b;
      c_op_slt: begin
        w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
        w_c   = w_cout;
        w_v   = w_ovf;
      end
      c_op_sltu: begin
        w_res = {{(WIDTH-1){1'b0}}, ~w_cout};
        w_c   = w_cout;
        w_v   = w_ovf;
      end
      c_op_sll:  w_res = a << w_shamt;
      c_op_srl:  w_res = a >> w_shamt;
      c_op_sra:  w_res = $unsigned($signed(a) >>> w_shamt);
      c_op_mul:  w_iter = 1'b1;
      c_op_divu: begin
        if (b == '0) begin
          w_res = '1;
          w_dz  = 1'b1;
        end else begin
          w_iter = 1'b1;
        end
      end
      c_op_remu: begin
        if (b == '0) begin
          w_res = a;
          w_dz  = 1'b1;
        end else begin
          w_iter = 1'b1;
        end
      end
      default:   w_res = '0;
    endcase
  end

  // One iteration step of shift-add multiply and restoring division
  always_comb begin
    w_acc_nxt = r_acc + (r_y[0] ? r_x : '0);
    w_ge      = (r_rem >= {1'b0, r_y});
    w_diff    = w_ge ? (r_rem[WIDTH-1:0] - r_y) : r_rem[WIDTH-1:0];
    case (r_op)
      c_op_mul:  w_fin = w_acc_nxt;
      c_op_divu: w_fin = {r_x[WIDTH-2:0], w_ge};
      default:   w_fin = w_diff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)
          w_state_nxt = w_iter ? S_BUSY : S_DONE;
        else if ((r_state == S_DONE) && out_ready)
          w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_op <= op;
      if (w_iter) begin
        r_cnt <= c_cnt_last;
        r_acc <= '0;
        r_y   <= b;
        if (op == c_op_mul) begin
          r_x <= a;
        end else begin
          r_x   <= {a[WIDTH-2:0], 1'b0};
          r_rem <= {{WIDTH{1'b0}}, a[WIDTH-1]};
        end
      end else begin
        r_result <= w_res;
        r_n      <= w_res[WIDTH-1];
        r_z      <= (w_res == '0);
        r_c      <= w_c;
        r_v      <= w_v;
        r_dz     <= w_dz;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_op == c_op_mul) begin
        r_acc <= w_acc_nxt;
        r_x   <= r_x << 1;
        r_y   <= r_y >> 1;
      end else begin
        r_rem <= {w_diff, r_x[WIDTH-1]};
        r_x   <= {r_x[WIDTH-2:0], w_ge};
      end
      if (r_cnt == '0) begin
        r_result <= w_fin;
        r_n      <= w_fin[WIDTH-1];
        r_z      <= (w_fin == '0);
        r_c      <= 1'b0;
        r_v      <= 1'b0;
        r_dz     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter
// Purpose  : Directed self-checking bench for alu_iter (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             div_zero;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  bit rdy_seen;

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offers one op (called just after a clock edge), waits for out_valid with a bound
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res,
                        input logic [3:0] exp_nzcv, input logic exp_dz, input int exp_lat);
    chk({tag, "_rdy"}, in_ready, 1);
    issue(o, x, y);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_nzcv"}, {flag_n, flag_z, flag_c, flag_v}, exp_nzcv);
    chk({tag, "_dz"}, div_zero, exp_dz);
    chk({tag, "_busyrdy"}, rdy_seen, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_n, flag_z, flag_c, flag_v, div_zero}, 0);
    chk("rst_ready", in_ready, 1);

    //        tag      op     a             b             result        NZCV     dz  lat
    run_op("add_ovf",  4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001, 0,  1);
    run_op("sub_eq",   4'd1,  32'd5,        32'd5,        32'h0,        4'b0110, 0,  1);
    run_op("slt",      4'd5,  32'hFFFFFFFF, 32'h1,        32'h1,        4'b0010, 0,  1);
    run_op("sltu",     4'd6,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b0110, 0,  1);
    run_op("and",      4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 4'b0000, 0, 1);
    run_op("or",       4'd3,  32'h8000_0001, 32'h0000_0010, 32'h8000_0011, 4'b1000, 0, 1);
    run_op("xor",      4'd4,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,      4'b0100, 0,  1);
    run_op("sra",      4'd9,  32'h80000000, 32'd4,        32'hF8000000, 4'b1000, 0,  1);
    run_op("srl",      4'd8,  32'h80000000, 32'd4,        32'h08000000, 4'b0000, 0,  1);
    run_op("sll33",    4'd7,  32'h1,        32'd33,       32'h2,        4'b0000, 0,  1);
    run_op("op13",     4'd13, 32'h1234,     32'h5678,     32'h0,        4'b0100, 0,  1);
    run_op("mul_ff",   4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 0, 33);
    run_op("mul_6x7",  4'd10, 32'd6,        32'd7,        32'd42,       4'b0000, 0, 33);
    run_op("divu",     4'd11, 32'd100,      32'd7,        32'd14,       4'b0000, 0, 33);
    run_op("remu",     4'd12, 32'd100,      32'd7,        32'd2,        4'b0000, 0, 33);
    run_op("divu_big", 4'd11, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 4'b0000, 0, 33);
    run_op("divu_z",   4'd11, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b1000, 1,  1);
    run_op("remu_z",   4'd12, 32'd9,        32'd0,        32'd9,        4'b0000, 1,  1);

    // Backpressure: held result stays put and in_ready stays low
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op("bp_add",   4'd0,  32'd10,       32'd20,       32'd30,       4'b0000, 0,  1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 30);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 4'd0;
    for (int i = 0; i < 4; i++) begin
      a = 32'd100 + i; b = 32'd1;
      @(posedge clk); #1;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_result", result, 32'd101 + i);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", out_valid, 0);

    // Reset in the middle of a multiply
    op = 4'd10; a = 32'd123; b = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_result", result, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_flags", {flag_n, flag_z, flag_c, flag_v, div_zero}, 0);
    run_op("post_rst", 4'd0,  32'd2,        32'd3,        32'd5,        4'b0000, 0,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
